// File: rtl/lfsr_cfg_master_if.sv
// LFSR configuration port: write strobe/data out, done/readback in,
// plus the run enable the master gates.
interface lfsr_cfg_master_if #(
  parameter int WORD_BITS = 24
);
  logic                 config_sel_o;
  logic                 config_rdy_o;
  logic [WORD_BITS-1:0] config_data_o;
  logic                 config_done_i;
  logic [WORD_BITS-1:0] config_data_i;
  logic                 lfsr_en_o;

  modport master (
    output config_sel_o,
    output config_rdy_o,
    output config_data_o,
    output lfsr_en_o,
    input  config_done_i,
    input  config_data_i
  );

  modport slave (
    input  config_sel_o,
    input  config_rdy_o,
    input  config_data_o,
    input  lfsr_en_o,
    output config_done_i,
    output config_data_i
  );
endinterface

// File: rtl/lfsr_cfg_master.sv
// Host byte stream -> LFSR seed/stop words, with write,
// readback verify, ok/err status and run gating.
module lfsr_cfg_master #(
  parameter int WORD_BITS   = 24,
  parameter int TIMEOUT_CYC = 8
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       byte_valid_i,
  input  logic [7:0] byte_data_i,
  output logic       byte_ready_o,
  input  logic       run_i,
  lfsr_cfg_master_if.master lfsr,
  output logic       busy_o,
  output logic       cfg_ok_o,
  output logic       cfg_err_o,
  output logic [1:0] err_code_o,
  output logic       seed_loaded_o,
  output logic       stop_loaded_o
);
  localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_WRITE,
    S_WAIT
  } state_e;

  state_e               state_q, state_d;
  logic [1:0]           cnt_q, cnt_d;
  logic [WORD_BITS-1:0] word_q, word_d;
  logic [WORD_BITS-1:0] data_q, data_d;
  logic [TW-1:0]        tmo_q, tmo_d;
  logic                 sel_q, sel_d;
  logic                 rdy_q, rdy_d;
  logic                 ready_q, ready_d;
  logic                 busy_q, busy_d;
  logic                 ok_q, ok_d;
  logic                 err_q, err_d;
  logic [1:0]           code_q, code_d;
  logic                 seed_q, seed_d;
  logic                 stop_q, stop_d;
  logic                 en_q, en_d;
  logic                 accept;

  assign accept = byte_valid_i & ready_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    data_d  = data_q;
    tmo_d   = tmo_q;
    sel_d   = sel_q;
    rdy_d   = 1'b0;
    ok_d    = 1'b0;
    err_d   = 1'b0;
    code_d  = code_q;
    seed_d  = seed_q;
    stop_d  = stop_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (byte_data_i == 8'hA0 || byte_data_i == 8'hA1) begin
            sel_d   = byte_data_i[0];
            cnt_d   = 2'd0;
            state_d = S_DATA;
          end else begin
            err_d  = 1'b1;
            code_d = 2'b01;
          end
        end
      end
      S_DATA: begin
        if (accept) begin
          word_d = {word_q[WORD_BITS-9:0], byte_data_i};
          cnt_d  = cnt_q + 2'd1;
          if (cnt_q == 2'd2) begin
            data_d  = word_d;
            rdy_d   = 1'b1;
            state_d = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        tmo_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (lfsr.config_done_i) begin
          if (lfsr.config_data_i == data_q) begin
            ok_d = 1'b1;
            if (sel_q) stop_d = 1'b1;
            else       seed_d = 1'b1;
          end else begin
            err_d  = 1'b1;
            code_d = 2'b11;
            if (sel_q) stop_d = 1'b0;
            else       seed_d = 1'b0;
          end
          state_d = S_IDLE;
        end else if (tmo_q == TMO_LAST) begin
          err_d  = 1'b1;
          code_d = 2'b10;
          if (sel_q) stop_d = 1'b0;
          else       seed_d = 1'b0;
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    ready_d = (state_d == S_IDLE) || (state_d == S_DATA);
    busy_d  = (state_d != S_IDLE);
    // Enable follows the current state so a new header drops it
    en_d = run_i & seed_q & stop_q & (state_q == S_IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      word_q  <= '0;
      data_q  <= '0;
      tmo_q   <= '0;
      sel_q   <= 1'b0;
      rdy_q   <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      ok_q    <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= '0;
      seed_q  <= 1'b0;
      stop_q  <= 1'b0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      data_q  <= data_d;
      tmo_q   <= tmo_d;
      sel_q   <= sel_d;
      rdy_q   <= rdy_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      ok_q    <= ok_d;
      err_q   <= err_d;
      code_q  <= code_d;
      seed_q  <= seed_d;
      stop_q  <= stop_d;
      en_q    <= en_d;
    end
  end

  assign byte_ready_o       = ready_q;
  assign busy_o             = busy_q;
  assign cfg_ok_o           = ok_q;
  assign cfg_err_o          = err_q;
  assign err_code_o         = code_q;
  assign seed_loaded_o      = seed_q;
  assign stop_loaded_o      = stop_q;
  assign lfsr.config_sel_o  = sel_q;
  assign lfsr.config_rdy_o  = rdy_q;
  assign lfsr.config_data_o = data_q;
  assign lfsr.lfsr_en_o     = en_q;
endmodule

// File: tb/tb_lfsr_cfg_master.sv
// Directed bench for lfsr_cfg_master with a small LFSR config model
// (done = rdy delayed, readback of selected register).
module tb_lfsr_cfg_master;
  localparam int T = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       byte_valid = 1'b0;
  logic [7:0] byte_data = '0;
  logic       byte_ready;
  logic       run = 1'b0;
  logic       busy, ok, err, seed_ld, stop_ld;
  logic [1:0] code;

  logic [23:0] seed_r = '0;
  logic [23:0] stop_r = '0;
  logic        done_r = 1'b0;
  logic        no_done = 1'b0;
  logic        corrupt = 1'b0;
  int          rdy_cnt = 0;
  int          n_chk = 0;
  int          n_fail = 0;

  lfsr_cfg_master_if #(.WORD_BITS(24)) lif ();

  lfsr_cfg_master #(.WORD_BITS(24), .TIMEOUT_CYC(T)) dut (
    .clk_i         (clk),
    .reset_i       (reset),
    .byte_valid_i  (byte_valid),
    .byte_data_i   (byte_data),
    .byte_ready_o  (byte_ready),
    .run_i         (run),
    .lfsr          (lif),
    .busy_o        (busy),
    .cfg_ok_o      (ok),
    .cfg_err_o     (err),
    .err_code_o    (code),
    .seed_loaded_o (seed_ld),
    .stop_loaded_o (stop_ld)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (lif.config_rdy_o) begin
      if (lif.config_sel_o) stop_r <= lif.config_data_o;
      else                  seed_r <= lif.config_data_o;
      rdy_cnt <= rdy_cnt + 1;
    end
    done_r <= lif.config_rdy_o & ~no_done;
  end

  assign lif.config_done_i = done_r;
  assign lif.config_data_i =
    (lif.config_sel_o ? stop_r : seed_r) ^ {23'd0, corrupt};

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    byte_valid = 1'b1;
    byte_data  = b;
    while (byte_ready !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    n_chk++;
    if (n >= 40) begin
      n_fail++;
      $display("FAIL byte_accept %h: ready=%b want 1", b, byte_ready);
    end
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] h, input logic [7:0] b0,
                            input logic [7:0] b1, input logic [7:0] b2,
                            input int gap);
    send_byte(h);
    repeat (gap) @(negedge clk);
    send_byte(b0);
    repeat (gap) @(negedge clk);
    send_byte(b1);
    repeat (gap) @(negedge clk);
    send_byte(b2);
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_chk++;
    if ({byte_ready, busy, ok, err, code, seed_ld, stop_ld} !== 8'h00 ||
        {lif.config_rdy_o, lif.config_sel_o, lif.lfsr_en_o} !== 3'b000 ||
        lif.config_data_o !== 24'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: rdy=%b busy=%b ok=%b err=%b want all 0",
               byte_ready, busy, ok, err);
    end
    reset = 1'b0;
    @(negedge clk);
    n_chk++;
    if (byte_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: ready=%b busy=%b want 1 0", byte_ready, busy);
    end
  endtask

  task automatic test_seed();
    int c0 = rdy_cnt;
    send_frame(8'hA0, 8'h12, 8'h34, 8'h56, 1);
    n_chk++;
    if (lif.config_rdy_o !== 1'b1 || lif.config_sel_o !== 1'b0 ||
        lif.config_data_o !== 24'h123456 || byte_ready !== 1'b0 ||
        busy !== 1'b1) begin
      n_fail++;
      $display("FAIL seed_write: rdy=%b sel=%b data=%h ready=%b want 1 0 123456 0",
               lif.config_rdy_o, lif.config_sel_o, lif.config_data_o, byte_ready);
    end
    @(negedge clk);
    n_chk++;
    if (lif.config_rdy_o !== 1'b0 || ok !== 1'b0 || rdy_cnt !== c0 + 1) begin
      n_fail++;
      $display("FAIL seed_strobe: rdy=%b ok=%b strobes=%0d want 0 0 %0d",
               lif.config_rdy_o, ok, rdy_cnt - c0, 1);
    end
    @(negedge clk);
    n_chk++;
    if (ok !== 1'b1 || err !== 1'b0 || seed_ld !== 1'b1 || byte_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL seed_ok: ok=%b err=%b seed=%b ready=%b want 1 0 1 1",
               ok, err, seed_ld, byte_ready);
    end
    @(negedge clk);
    n_chk++;
    if (ok !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL seed_ok_width: ok=%b busy=%b want 0 0", ok, busy);
    end
  endtask

  task automatic test_stop_run();
    run = 1'b1;
    send_frame(8'hA1, 8'h00, 8'h00, 8'hFF, 0);
    n_chk++;
    if (lif.config_sel_o !== 1'b1 || lif.config_data_o !== 24'h0000FF) begin
      n_fail++;
      $display("FAIL stop_write: sel=%b data=%h want 1 0000ff",
               lif.config_sel_o, lif.config_data_o);
    end
    repeat (2) @(negedge clk);
    n_chk++;
    if (ok !== 1'b1 || stop_ld !== 1'b1 || lif.lfsr_en_o !== 1'b0) begin
      n_fail++;
      $display("FAIL stop_ok: ok=%b stop=%b en=%b want 1 1 0", ok, stop_ld, lif.lfsr_en_o);
    end
    @(negedge clk);
    n_chk++;
    if (lif.lfsr_en_o !== 1'b1) begin
      n_fail++;
      $display("FAIL run_enable: en=%b want 1", lif.lfsr_en_o);
    end
    send_byte(8'hA0);
    @(negedge clk);
    n_chk++;
    if (lif.lfsr_en_o !== 1'b0) begin
      n_fail++;
      $display("FAIL header_drops_en: en=%b want 0", lif.lfsr_en_o);
    end
    send_frame(8'h12, 8'h34, 8'h56, 8'h00, 0);
  endtask

  task automatic test_bad_header();
    int c0;
    repeat (4) @(negedge clk);
    c0 = rdy_cnt;
    send_byte(8'h55);
    n_chk++;
    if (err !== 1'b1 || code !== 2'b01 || ok !== 1'b0 ||
        busy !== 1'b0 || byte_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bad_header: err=%b code=%b busy=%b want 1 01 0", err, code, busy);
    end
    @(negedge clk);
    n_chk++;
    if (err !== 1'b0 || code !== 2'b01 || rdy_cnt !== c0) begin
      n_fail++;
      $display("FAIL bad_header_after: err=%b code=%b strobes=%0d want 0 01 0",
               err, code, rdy_cnt - c0);
    end
    send_frame(8'hA0, 8'h11, 8'h22, 8'h33, 0);
    repeat (2) @(negedge clk);
    n_chk++;
    if (ok !== 1'b1 || seed_r !== 24'h112233 || seed_ld !== 1'b1) begin
      n_fail++;
      $display("FAIL after_bad_ok: ok=%b seed=%h want 1 112233", ok, seed_r);
    end
  endtask

  task automatic test_timeout();
    no_done = 1'b1;
    @(negedge clk);
    send_frame(8'hA1, 8'hAA, 8'hBB, 8'hCC, 0);
    for (int k = 1; k <= T; k++) begin
      @(negedge clk);
      n_chk++;
      if (err !== 1'b0 || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL timeout_early k=%0d: err=%b busy=%b want 0 1", k, err, busy);
      end
    end
    @(negedge clk);
    n_chk++;
    if (err !== 1'b1 || code !== 2'b10 || stop_ld !== 1'b0 ||
        seed_ld !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout: err=%b code=%b stop=%b seed=%b want 1 10 0 1",
               err, code, stop_ld, seed_ld);
    end
    no_done = 1'b0;
  endtask

  task automatic test_mismatch();
    @(negedge clk);
    send_frame(8'hA1, 8'h00, 8'h00, 8'hFF, 0);
    repeat (3) @(negedge clk);
    n_chk++;
    if (lif.lfsr_en_o !== 1'b1) begin
      n_fail++;
      $display("FAIL mismatch_pre_en: en=%b want 1", lif.lfsr_en_o);
    end
    corrupt = 1'b1;
    send_frame(8'hA0, 8'h12, 8'h34, 8'h56, 0);
    repeat (2) @(negedge clk);
    n_chk++;
    if (err !== 1'b1 || code !== 2'b11 || ok !== 1'b0 || seed_ld !== 1'b0) begin
      n_fail++;
      $display("FAIL mismatch: err=%b code=%b ok=%b seed=%b want 1 11 0 0",
               err, code, ok, seed_ld);
    end
    @(negedge clk);
    n_chk++;
    if (lif.lfsr_en_o !== 1'b0 || err !== 1'b0 || stop_ld !== 1'b1) begin
      n_fail++;
      $display("FAIL mismatch_en: en=%b err=%b stop=%b want 0 0 1",
               lif.lfsr_en_o, err, stop_ld);
    end
    corrupt = 1'b0;
  endtask

  task automatic test_reset_mid();
    int c0 = rdy_cnt;
    send_byte(8'hA0);
    send_byte(8'hAB);
    send_byte(8'hCD);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_chk++;
    if ({byte_ready, busy, ok, err, code, seed_ld, stop_ld} !== 8'h00 ||
        {lif.config_rdy_o, lif.config_sel_o, lif.lfsr_en_o} !== 3'b000 ||
        lif.config_data_o !== 24'h0) begin
      n_fail++;
      $display("FAIL reset_mid: ready=%b busy=%b stop=%b data=%h want all 0",
               byte_ready, busy, stop_ld, lif.config_data_o);
    end
    @(negedge clk);
    n_chk++;
    if (byte_ready !== 1'b1 || rdy_cnt !== c0) begin
      n_fail++;
      $display("FAIL reset_mid_strobe: ready=%b strobes=%0d want 1 0",
               byte_ready, rdy_cnt - c0);
    end
    send_frame(8'hA0, 8'hAB, 8'hCD, 8'hEF, 0);
    n_chk++;
    if (lif.config_data_o !== 24'hABCDEF || lif.config_rdy_o !== 1'b1) begin
      n_fail++;
      $display("FAIL fresh_write: data=%h rdy=%b want abcdef 1",
               lif.config_data_o, lif.config_rdy_o);
    end
    repeat (2) @(negedge clk);
    n_chk++;
    if (ok !== 1'b1 || seed_ld !== 1'b1 || stop_ld !== 1'b0) begin
      n_fail++;
      $display("FAIL fresh_ok: ok=%b seed=%b stop=%b want 1 1 0", ok, seed_ld, stop_ld);
    end
  endtask

  initial begin
    test_reset();
    test_seed();
    test_stop_run();
    test_bad_header();
    test_timeout();
    test_mismatch();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
